// File: rtl/seg_shift_out.sv
// Serial output stage: shifts a 64-bit segment pattern MSB-first into an external 74HC595-style chain and then latches it.
// Latency: busy for 129*DIV cycles from the accepting edge, then done pulses for one cycle.
// Backpressure: start is honoured only in IDLE; requests made while a frame is in flight are dropped.
module seg_shift_out #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] seg_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_latch,
    output logic        seg_clrn
);

    localparam int PCW = $clog2(DIV + 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);
    localparam logic [PCW-1:0] PC_ONE  = PCW'(1);
    localparam logic [PCW-1:0] PC_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    sr_q, sr_d;
    logic [6:0]     bc_q, bc_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           seg_clk_q, seg_clk_d;
    logic           seg_latch_q, seg_latch_d;
    logic           seg_clrn_q;
    logic           pc_last;

    assign pc_last = (pc_q == PC_LAST);

    // Next-state, datapath and output decode; outputs come from next state so they are flop outputs.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bc_d    = bc_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = seg_data;
                    bc_d    = 7'd0;
                    pc_d    = PC_ZERO;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (pc_last) begin
                    pc_d    = PC_ZERO;
                    state_d = S_HI;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            S_HI: begin
                if (pc_last) begin
                    pc_d = PC_ZERO;
                    if (bc_q == 7'd63) begin
                        state_d = S_LATCH;
                    end else begin
                        // Shift only as seg_clk falls so seg_sout is stable across the whole HI phase.
                        sr_d    = {sr_q[62:0], 1'b0};
                        bc_d    = bc_q + 7'd1;
                        state_d = S_LO;
                    end
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            S_LATCH: begin
                if (pc_last) begin
                    pc_d    = PC_ZERO;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d != S_IDLE);
        seg_clk_d   = (state_d == S_HI);
        seg_latch_d = (state_d == S_LATCH);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bc_q        <= '0;
            pc_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_clk_q   <= 1'b0;
            seg_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bc_q        <= bc_d;
            pc_q        <= pc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seg_clk_q   <= seg_clk_d;
            seg_latch_q <= seg_latch_d;
        end
    end

    // External chain clear: held low through reset, released on the first edge afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_clrn_q <= 1'b0;
        end else begin
            seg_clrn_q <= 1'b1;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign seg_clk   = seg_clk_q;
    assign seg_sout  = sr_q[63];
    assign seg_latch = seg_latch_q;
    assign seg_clrn  = seg_clrn_q;

endmodule

// File: doc/seg_shift_out.md
# seg_shift_out

Serial output stage for the eight-digit seven-segment display. Takes the 64-bit segment pattern produced by the hex-to-segment converter and shifts it MSB-first into the board's external 74HC595-style shift-register chain, then pulses the chain's latch. The display only changes when the latch pulses, so it never shows partially shifted data. Frames run on request; upstream logic decides the refresh rate.

## Interface
- `DIV`, default 4: half-period of `seg_clk` in `clk` cycles; legal range 1..255.
- `clk`  input  1: system clock; all logic is on the rising edge.
- `rstn`  input  1: asynchronous, active-low reset.
- `seg_data`  input  64: segment pattern; digit 0 in [7:0], digit 7 in [63:56].
- `start`  input  1: frame request; sampled only in IDLE.
- `busy`  output  1: high while a frame is in progress.
- `done`  output  1: one-cycle pulse when a frame completes.
- `seg_clk`  output  1: serial shift clock to the external chain.
- `seg_sout`  output  1: serial data to the external chain.
- `seg_latch`  output  1: storage-register latch pulse, active high.
- `seg_clrn`  output  1: active-low clear for the external chain.

## Operation
- States:
  - IDLE: outputs quiescent.
  - LO: `seg_clk`=0, `seg_sout` driven and settling.
  - HI: `seg_clk`=1, external chain samples on the rising edge.
  - LATCH: `seg_latch`=1.
- Registers:
  - 64-bit shift register `sr`.
  - 7-bit bit counter `bc` (0..63).
  - Phase counter `pc`, width clog2(DIV+1).
- IDLE with `start`=1: load `sr`←`seg_data`, `bc`←0, `pc`←0, then go to LO.
- In every state other than IDLE, `seg_data` and `start` are ignored. Later changes to the input do not affect the frame in flight.
- `seg_sout` is always `sr[63]`; the MSB is shifted first.
- LO: when `pc`=DIV-1, go to HI and clear `pc`; otherwise increment `pc`.
- HI: when `pc`=DIV-1:
  - If `bc`=63, go to LATCH.
  - Otherwise shift `sr` left by one (zero fill), increment `bc`, and go to LO.
  - Clear `pc` in both cases.
- LATCH: lasts DIV cycles, then go to IDLE. `done` is 1 in the first IDLE cycle.
- All outputs are registered and glitch-free. `seg_clk` and `seg_latch` are never high in the same cycle.
- `seg_clrn`:
  - Asynchronously forced to 0 while `rstn`=0.
  - Set to 1 on the first `clk` edge after `rstn` rises.
  - Stays 1 thereafter.

## Timing
- Reset values (immediate, asynchronous):
  - State = IDLE.
  - `busy`=0, `done`=0, `seg_clk`=0, `seg_latch`=0, `seg_clrn`=0.
  - `sr`=0, so `seg_sout`=0.
- Frame start and length:
  - Edge E0 samples `start`=1 in IDLE.
  - From E0, `busy`=1 for exactly 129·DIV cycles: 64 bits × 2·DIV, plus DIV for LATCH.
  - On the cycle `busy` falls, `done`=1 for exactly one cycle.
- Bit timing:
  - Bit k (k=0 is `seg_data[63]`) is valid on `seg_sout` from cycle 2k·DIV after E0.
  - It is held through the whole HI phase that follows; `seg_clk` rises at cycle (2k+1)·DIV.
  - Setup and hold at the external chain are therefore each DIV cycles.
- Back-to-back frames: `start`=1 in the same cycle `done`=1 is accepted. The idle gap between frames is then exactly one cycle.
- `start` held high continuously causes frames to repeat every 129·DIV+1 cycles.
- Reset mid-frame: the frame is aborted with no latch pulse. The external chain is cleared via `seg_clrn`; the next frame needs a fresh `start`.
- DIV=1 is legal: `seg_clk` toggles every cycle and a frame lasts 129 cycles.

## Test plan
- Reset: `rstn`=0 mid-LO with DIV=4 -> all outputs go to their reset values within the same cycle; `seg_clrn` returns to 1 one edge after release.
- Single frame, DIV=2, `seg_data`=64'hF0F0_0000_0000_0001:
  - `busy` is high for 258 cycles; 64 `seg_clk` rising edges; one `seg_latch` pulse 2 cycles wide; `done` pulses once.
  - A 64-bit shift-register model captures 64'hF0F0_0000_0000_0001.
- Snapshot: change `seg_data` from 64'hAAAA_AAAA_AAAA_AAAA to 64'h5555_5555_5555_5555 at cycle 10 of a frame -> the captured value is 64'hAAAA_AAAA_AAAA_AAAA.
- `start` ignored while busy: pulse `start` at cycles 5 and 100 of a frame -> exactly one frame and one `done`.
- Back-to-back, DIV=1: hold `start`=1 -> frames repeat every 130 cycles; one-cycle `busy`=0 gap each time `done`=1; the second frame carries the newly sampled `seg_data`.
- Protocol checker on all runs:
  - `seg_sout` never changes while `seg_clk`=1.
  - `seg_clk` and `seg_latch` are never both 1.
  - `seg_clk`=0 in IDLE and LATCH.
